// File: rtl/iot_event_sequencer.sv
// Event front-end for the active-device counter: filters per-device connect/disconnect
// pulses, serialises survivors round-robin into single change/on_off steps.
module iot_event_sequencer #(
    parameter int N_DEV    = 8,
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_DEV-1:0] i_evt_valid,
    input  logic [N_DEV-1:0] i_evt_on,
    output logic             o_change,
    output logic             o_on_off,
    output logic [N_DEV-1:0] o_dev_active,
    output logic [CNT_W-1:0] o_active_cnt,
    output logic             o_busy,
    output logic             o_evt_ovf
);

    localparam int IDX_W = $clog2(N_DEV);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_DEV-1:0] r_pend;
    logic [N_DEV-1:0] r_dir;
    logic [N_DEV-1:0] r_dev_active;
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] r_g;
    logic             r_dir_g;
    logic [3:0]       r_hold_cnt;
    logic             r_change;
    logic             r_on_off;
    logic             r_evt_ovf;
    logic [CNT_W-1:0] r_active_cnt;

    logic [N_DEV-1:0] w_rot;
    logic             w_found;
    logic [IDX_W-1:0] w_sel;
    logic             w_take;
    logic             w_redundant;
    logic             w_start;
    logic [N_DEV-1:0] w_take_mask;
    logic [N_DEV-1:0] w_pend_base;
    logic [N_DEV-1:0] w_pend_nxt;
    logic [N_DEV-1:0] w_dir_nxt;
    logic             w_ovf_set;
    logic             w_change_nxt;
    logic             w_on_off_nxt;

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W:0] s);
        logic [IDX_W:0] v;
        v = (s >= (IDX_W+1)'(N_DEV)) ? s - (IDX_W+1)'(N_DEV) : s;
        return v[IDX_W-1:0];
    endfunction

    // Rotate pending so bit 0 is the rr position; first set bit is the winner.
    always_comb begin
        w_rot   = N_DEV'({r_pend, r_pend} >> r_rr);
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_DEV; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sel   = f_wrap({1'b0, r_rr} + (IDX_W+1)'(k));
            end
        end
    end

    assign w_take      = (r_state == S_IDLE) && w_found;
    assign w_redundant = (r_dir[w_sel] == r_dev_active[w_sel]);
    assign w_start     = w_take && !w_redundant;
    assign w_take_mask = w_take ? (N_DEV'(1) << w_sel) : '0;
    assign w_pend_base = r_pend & ~w_take_mask;

    // A granted device's old event is consumed first, so a same-edge event lands fresh.
    always_comb begin
        w_pend_nxt = w_pend_base;
        w_dir_nxt  = r_dir;
        w_ovf_set  = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (i_evt_valid[i]) begin
                if (!w_pend_base[i]) begin
                    w_pend_nxt[i] = 1'b1;
                    w_dir_nxt[i]  = i_evt_on[i];
                end else if (i_evt_on[i] != r_dir[i]) begin
                    w_pend_nxt[i] = 1'b0;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = (HOLD_CYC > 0) ? S_HOLD : S_IDLE;
            S_HOLD:  if (r_hold_cnt == 4'd0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_change_nxt = (w_state_nxt == S_ISSUE);
        w_on_off_nxt = w_change_nxt ? r_dir[w_sel] : r_on_off;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend       <= '0;
            r_dir        <= '0;
            r_dev_active <= '0;
            r_rr         <= '0;
            r_g          <= '0;
            r_dir_g      <= 1'b0;
            r_hold_cnt   <= '0;
            r_change     <= 1'b0;
            r_on_off     <= 1'b0;
            r_evt_ovf    <= 1'b0;
            r_active_cnt <= '0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_dir     <= w_dir_nxt;
            r_change  <= w_change_nxt;
            r_on_off  <= w_on_off_nxt;
            r_evt_ovf <= r_evt_ovf | w_ovf_set;
            if (w_take && w_redundant) begin
                r_rr <= f_wrap({1'b0, w_sel} + (IDX_W+1)'(1));
            end
            if (w_start) begin
                r_g     <= w_sel;
                r_dir_g <= r_dir[w_sel];
            end
            // The counter-visible state only moves as the command leaves ISSUE.
            if (r_state == S_ISSUE) begin
                r_dev_active <= r_dev_active ^ (N_DEV'(1) << r_g);
                r_active_cnt <= r_dir_g ? r_active_cnt + CNT_W'(1) : r_active_cnt - CNT_W'(1);
                r_rr         <= f_wrap({1'b0, r_g} + (IDX_W+1)'(1));
                r_hold_cnt   <= 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
            end else if (r_state == S_HOLD && r_hold_cnt != 4'd0) begin
                r_hold_cnt <= r_hold_cnt - 4'd1;
            end
        end
    end

    assign o_change     = r_change;
    assign o_on_off     = r_on_off;
    assign o_dev_active = r_dev_active;
    assign o_active_cnt = r_active_cnt;
    assign o_evt_ovf    = r_evt_ovf;
    assign o_busy       = (r_state != S_IDLE) | (|r_pend);

endmodule

// File: tb/tb_iot_event_sequencer.sv
// Bench for iot_event_sequencer: directed vector table, hand-written corner sequences,
// and randomized events checked against a timestamp-based reference model.
module tb_iot_event_sequencer;

    localparam int N  = 8;
    localparam int H  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [N-1:0]  i_evt_valid = '0;
    logic [N-1:0]  i_evt_on = '0;
    logic          o_change;
    logic          o_on_off;
    logic [N-1:0]  o_dev_active;
    logic [CW-1:0] o_active_cnt;
    logic          o_busy;
    logic          o_evt_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    iot_event_sequencer #(.N_DEV(N), .HOLD_CYC(H), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_evt_valid  (i_evt_valid),
        .i_evt_on     (i_evt_on),
        .o_change     (o_change),
        .o_on_off     (o_on_off),
        .o_dev_active (o_dev_active),
        .o_active_cnt (o_active_cnt),
        .o_busy       (o_busy),
        .o_evt_ovf    (o_evt_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: pending events per device, plus timestamps for when the
    // sequencer may arbitrate again and when an issued step lands in the bitmap.
    logic [N-1:0] m_pend, m_dir, m_act;
    logic         m_change, m_on_off, m_ovf;
    int           m_rr, m_t, m_free_at, m_apply_at, m_apply_g;

    task automatic modelReset();
        m_pend = '0; m_dir = '0; m_act = '0;
        m_change = 1'b0; m_on_off = 1'b0; m_ovf = 1'b0;
        m_rr = 0; m_t = 0; m_free_at = 0; m_apply_at = -1; m_apply_g = 0;
    endtask

    task automatic modelStep(input logic [N-1:0] v, input logic [N-1:0] on);
        int g;
        g = -1;
        m_change = 1'b0;
        if (m_apply_at == m_t) m_act[m_apply_g] = ~m_act[m_apply_g];
        if (m_t >= m_free_at) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % N;
                if (m_dir[g] == m_act[g]) begin
                    m_free_at = m_t + 1;
                end else begin
                    m_change   = 1'b1;
                    m_on_off   = m_dir[g];
                    m_apply_at = m_t + 1;
                    m_apply_g  = g;
                    m_free_at  = m_t + 2 + H;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1'b1;
                    m_dir[i]  = on[i];
                end else if (on[i] != m_dir[i]) begin
                    m_pend[i] = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_t++;
    endtask

    task automatic checkOutput(input string name, input logic chg, input logic oo,
                               input logic [N-1:0] dev, input int cnt,
                               input logic busy, input logic ovf);
        n_checks++;
        if (o_change !== chg || o_on_off !== oo || o_dev_active !== dev ||
            o_active_cnt !== CW'(cnt) || o_busy !== busy || o_evt_ovf !== ovf) begin
            n_fail++;
            $display("[TB] FAIL %s: got chg=%0b oo=%0b dev=%h cnt=%0d busy=%0b ovf=%0b, want chg=%0b oo=%0b dev=%h cnt=%0d busy=%0b ovf=%0b",
                     name, o_change, o_on_off, o_dev_active, o_active_cnt, o_busy, o_evt_ovf,
                     chg, oo, dev, cnt, busy, ovf);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, step the model on the rising edge,
    // compare just after it.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] on);
        @(negedge clk);
        i_evt_valid = v;
        i_evt_on    = on;
        @(posedge clk);
        modelStep(v, on);
        #1;
        checkOutput("model", m_change, m_on_off, m_act, $countones(m_act),
                    (m_t < m_free_at) || (|m_pend), m_ovf);
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        i_evt_valid = '0;
        i_evt_on = '0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset", 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] v;
        logic [7:0] on;
        logic       chg;
        logic       oo;
        logic [7:0] dev;
        int         cnt;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t tbl[17];

    int   npulse, lastc, spacing_ok, order_ok, np2;
    logic [N-1:0] exp_mask;
    logic chk_next;
    logic [N-1:0] pulse_dev[2];
    logic pulse_oo[2];
    logic [N-1:0] rv;

    initial begin
        // Single connect on device 3, then duplicate / redundant handling on device 5.
        tbl[0]  = '{8'h08, 8'h08, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        tbl[1]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0};
        tbl[2]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h08, 1, 1'b1, 1'b0};
        tbl[3]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h08, 1, 1'b1, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h08, 1, 1'b0, 1'b0};
        tbl[5]  = '{8'h01, 8'h01, 1'b0, 1'b1, 8'h08, 1, 1'b1, 1'b0};
        tbl[6]  = '{8'h20, 8'h20, 1'b1, 1'b1, 8'h08, 1, 1'b1, 1'b0};
        tbl[7]  = '{8'h20, 8'h20, 1'b0, 1'b1, 8'h09, 2, 1'b1, 1'b1};
        tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h09, 2, 1'b1, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h09, 2, 1'b1, 1'b1};
        tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h09, 2, 1'b1, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h29, 3, 1'b1, 1'b1};
        tbl[12] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h29, 3, 1'b1, 1'b1};
        tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h29, 3, 1'b0, 1'b1};
        tbl[14] = '{8'h20, 8'h20, 1'b0, 1'b1, 8'h29, 3, 1'b1, 1'b1};
        tbl[15] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h29, 3, 1'b0, 1'b1};
        tbl[16] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h29, 3, 1'b0, 1'b1};

        modelReset();
        doReset();
        for (int r = 0; r < 17; r++) begin
            applyStimulus(tbl[r].v, tbl[r].on);
            checkOutput($sformatf("tbl%0d", r), tbl[r].chg, tbl[r].oo, tbl[r].dev,
                        tbl[r].cnt, tbl[r].busy, tbl[r].ovf);
        end

        // All eight devices connect at once: served 0..7, one step every 2+H cycles.
        doReset();
        applyStimulus(8'hFF, 8'hFF);
        npulse = 0; lastc = -100; spacing_ok = 1; order_ok = 1; chk_next = 1'b0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus('0, '0);
            if (chk_next && o_dev_active != exp_mask) order_ok = 0;
            chk_next = 1'b0;
            if (o_change) begin
                if (npulse > 0 && c - lastc != H + 2) spacing_ok = 0;
                if (!o_on_off) order_ok = 0;
                lastc = c;
                npulse++;
                exp_mask = N'((1 << npulse) - 1);
                chk_next = 1'b1;
            end
        end
        checkValue("t2_pulses", npulse, 8);
        checkValue("t2_spacing", spacing_ok, 1);
        checkValue("t2_order", order_ok, 1);
        checkValue("t2_dev", int'(o_dev_active), 8'hFF);
        checkValue("t2_cnt", int'(o_active_cnt), 8);

        // Device 2 connect then disconnect while device 0 is being served: cancels.
        doReset();
        applyStimulus(8'h01, 8'h01);
        applyStimulus(8'h04, 8'h04);
        applyStimulus(8'h04, 8'h00);
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus('0, '0);
            if (o_change) npulse++;
        end
        checkValue("t4_pulses", npulse, 0);
        checkValue("t4_dev2", int'(o_dev_active[2]), 0);
        checkValue("t4_dev", int'(o_dev_active), 1);

        // rr lands on 2 after serving device 1; 6 must go before the wrapped 1.
        doReset();
        applyStimulus(8'h02, 8'h02);
        applyStimulus('0, '0);
        applyStimulus(8'h42, 8'h40);
        np2 = 0; chk_next = 1'b0;
        for (int c = 0; c < 14; c++) begin
            applyStimulus('0, '0);
            if (chk_next) pulse_dev[np2-1] = o_dev_active;
            chk_next = 1'b0;
            if (o_change) begin
                if (np2 < 2) begin
                    pulse_oo[np2] = o_on_off;
                    chk_next = 1'b1;
                end
                np2++;
            end
        end
        checkValue("t5_pulses", np2, 2);
        checkValue("t5_first_oo", int'(pulse_oo[0]), 1);
        checkValue("t5_first_dev", int'(pulse_dev[0]), 8'h42);
        checkValue("t5_second_oo", int'(pulse_oo[1]), 0);
        checkValue("t5_second_dev", int'(pulse_dev[1]), 8'h40);

        // Reset in the middle of ISSUE with more events still pending.
        doReset();
        applyStimulus(8'h0F, 8'h0F);
        applyStimulus('0, '0);
        checkValue("t6_in_issue", int'(o_change), 1);
        #2;
        i_rst = 1'b1;
        #1;
        modelReset();
        checkOutput("t6_async_rst", 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        i_rst = 1'b0;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus('0, '0);
            if (o_change) npulse++;
        end
        checkValue("t6_pulses", npulse, 0);
        checkValue("t6_dev", int'(o_dev_active), 0);

        // Sparse random events against the model, with one reset partway through.
        doReset();
        for (int c = 0; c < 500; c++) begin
            if (c == 250) doReset();
            rv = N'($urandom & $urandom & $urandom);
            applyStimulus(rv, N'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
